// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Shared constants and state types for the UART command receiver.
// The frame header, the command codes and the oversampling limit are defined here.
// The FSM state enums are defined here too.
// The top module uart_cmd_rx and its sub-module uart_rx_byte both import this package.
package uart_cmd_pkg;

    localparam logic [7:0] HDR       = 8'hA5;
    localparam logic [7:0] CMD_RUN   = 8'h01;
    localparam logic [7:0] CMD_OS    = 8'h02;
    localparam logic [7:0] CMD_RANGE = 8'h03;
    localparam logic [7:0] CMD_DIV   = 8'h04;
    localparam logic [7:0] OS_MAX    = 8'd6;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    typedef enum logic [2:0] {
        P_HDR,
        P_CMD,
        P_HI,
        P_LO,
        P_SUM
    } parse_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// Receives 8N1 bytes: a 2-flop synchroniser feeds a byte FSM.
//   clk, rst   : system clock; asynchronous active-high reset
//   uart_rx    : serial line, idle high, asynchronous to clk
//   byte_vld   : one-cycle pulse, asserted the cycle after a good stop-bit sample
//   byte_data  : received byte (LSB first on the line), valid while byte_vld is high
//   rx_err     : one-cycle pulse when a stop bit is sampled low
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_CNT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       rx_err
);

    localparam int HALF  = BAUD_CNT / 2;
    localparam int CNT_W = $clog2(BAUD_CNT + 1);

    logic             rx_s1, rx_s2, rx_prev;
    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             vld_nxt, err_nxt;

    // The synchroniser flops reset to the idle level.
    // This stops reset release from looking like a start edge.
    // NOTE: non-blocking assignments make each flop take the previous stage's old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            byte_vld <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            byte_vld <= vld_nxt;
            rx_err   <= err_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can leave one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        vld_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_nxt = '0;
                if (rx_prev && !rx_s2) state_nxt = RX_START;
            end
            RX_START: begin
                // Re-check the start bit at mid-bit.
                // A short low pulse is treated as a glitch and dropped.
                if (cnt == CNT_W'(HALF)) begin
                    cnt_nxt = '0;
                    bit_nxt = '0;
                    state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CNT_W'(BAUD_CNT - 1)) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s2, shift[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == CNT_W'(BAUD_CNT - 1)) begin
                    cnt_nxt = '0;
                    if (rx_s2) begin
                        vld_nxt   = 1'b1;
                        state_nxt = RX_IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                // A break holds the line low.
                // Wait for the line to go high so the break is not read as a string of start bits.
                cnt_nxt = '0;
                if (rx_s2) state_nxt = RX_IDLE;
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    assign byte_data = shift;

endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
// Host-to-FPGA UART command receiver. It parses 5-byte frames: A5, CMD, D_HI, D_LO, SUM.
// Accepted frames update the AD7606 control registers.
//   clk, rst  : system clock; asynchronous active-high reset
//   uart_rx   : serial input, 8N1, idle high
//   adc_run   : continuous-sampling enable
//   adc_os    : oversampling code 0..6
//   adc_range : 0 = +/-5 V, 1 = +/-10 V
//   adc_div   : clk cycles per conversion, never 0
//   cfg_valid : one-cycle pulse when a frame is accepted
//   frame_err : one-cycle pulse when a frame or byte is rejected
// Optional macro UART_CMD_TIMEOUT_EN enables an inter-byte timeout in the parser.
// The timeout is 16 bit-times.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FRE   = 50,
    parameter int UART_RATE = 115200,
    parameter int DIV_RST   = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        adc_run,
    output logic [2:0]  adc_os,
    output logic        adc_range,
    output logic [15:0] adc_div,
    output logic        cfg_valid,
    output logic        frame_err
);

    localparam int BAUD_CNT = CLK_FRE * 1_000_000 / UART_RATE;

    logic       byte_vld, rx_err;
    logic [7:0] byte_data;

    uart_rx_byte #(.BAUD_CNT(BAUD_CNT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .byte_vld (byte_vld),
        .byte_data(byte_data),
        .rx_err   (rx_err)
    );

    parse_state_t pstate, pstate_nxt;
    logic [7:0]   cmd_q, hi_q, lo_q, cmd_nxt, hi_nxt, lo_nxt;
    logic         run_nxt, range_nxt, cv_nxt, fe_nxt;
    logic [2:0]   os_nxt;
    logic [15:0]  div_nxt;
    logic [7:0]   sum;
    logic         timeout_hit;

    assign sum = cmd_q + hi_q + lo_q;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 16 * BAUD_CNT;
    localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    // The counter runs only while a frame is in progress.
    // It restarts on every received byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              to_cnt <= '0;
        else if (pstate == P_HDR || byte_vld) to_cnt <= '0;
        else if (!timeout_hit)                to_cnt <= to_cnt + TO_W'(1);
    end
    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pstate    <= P_HDR;
            cmd_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            adc_run   <= 1'b0;
            adc_os    <= 3'd0;
            adc_range <= 1'b0;
            adc_div   <= 16'(DIV_RST);
            cfg_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            pstate    <= pstate_nxt;
            cmd_q     <= cmd_nxt;
            hi_q      <= hi_nxt;
            lo_q      <= lo_nxt;
            adc_run   <= run_nxt;
            adc_os    <= os_nxt;
            adc_range <= range_nxt;
            adc_div   <= div_nxt;
            cfg_valid <= cv_nxt;
            frame_err <= fe_nxt;
        end
    end

    always_comb begin
        pstate_nxt = pstate;
        cmd_nxt    = cmd_q;
        hi_nxt     = hi_q;
        lo_nxt     = lo_q;
        run_nxt    = adc_run;
        os_nxt     = adc_os;
        range_nxt  = adc_range;
        div_nxt    = adc_div;
        cv_nxt     = 1'b0;
        fe_nxt     = 1'b0;
        if (rx_err) begin
            // A framing error aborts a partial frame.
            // A framing error between frames is ignored silently.
            if (pstate != P_HDR) begin
                pstate_nxt = P_HDR;
                fe_nxt     = 1'b1;
            end
        end else if (byte_vld) begin
            case (pstate)
                P_HDR: if (byte_data == HDR) pstate_nxt = P_CMD;
                P_CMD: begin cmd_nxt = byte_data; pstate_nxt = P_HI;  end
                P_HI:  begin hi_nxt  = byte_data; pstate_nxt = P_LO;  end
                P_LO:  begin lo_nxt  = byte_data; pstate_nxt = P_SUM; end
                P_SUM: begin
                    pstate_nxt = P_HDR;
                    fe_nxt     = 1'b1;
                    if (byte_data == sum) begin
                        case (cmd_q)
                            CMD_RUN: begin
                                run_nxt = lo_q[0];
                                fe_nxt  = 1'b0;
                            end
                            CMD_OS: if (lo_q <= OS_MAX) begin
                                os_nxt = lo_q[2:0];
                                fe_nxt = 1'b0;
                            end
                            CMD_RANGE: begin
                                range_nxt = lo_q[0];
                                fe_nxt    = 1'b0;
                            end
                            CMD_DIV: if ({hi_q, lo_q} != 16'd0) begin
                                div_nxt = {hi_q, lo_q};
                                fe_nxt  = 1'b0;
                            end
                            default: fe_nxt = 1'b1;
                        endcase
                    end
                    cv_nxt = !fe_nxt;
                end
                default: pstate_nxt = P_HDR;
            endcase
        end else if (timeout_hit) begin
            pstate_nxt = P_HDR;
            fe_nxt     = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx
// Self-checking bench for uart_cmd_rx.
// The bit time is shortened to 16 clocks: CLK_FRE=1 MHz, UART_RATE=62500.
// Checks run in this order:
//   - a table of frames with constant expected results;
//   - hand-written multi-cycle sequences;
//   - random frames checked against a frame-level reference model.
// Build with UART_CMD_TIMEOUT_EN defined to exercise the timeout path.
module tb_uart_cmd_rx;

    localparam int B    = 16;
    localparam int HALF = B / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_rx;
    logic        adc_run;
    logic [2:0]  adc_os;
    logic        adc_range;
    logic [15:0] adc_div;
    logic        cfg_valid;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cv_cnt = 0, fe_cnt = 0, overlap = 0;
    int last_cv_cyc = 0, sum_start_cyc = 0;

    uart_cmd_rx #(.CLK_FRE(1), .UART_RATE(62500), .DIV_RST(50000)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .adc_run  (adc_run),
        .adc_os   (adc_os),
        .adc_range(adc_range),
        .adc_div  (adc_div),
        .cfg_valid(cfg_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (cfg_valid) begin
            cv_cnt      <= cv_cnt + 1;
            last_cv_cyc <= cyc;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (cfg_valid && frame_err) overlap <= overlap + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        @(negedge clk);
        sum_start_cyc = cyc;
        uart_rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (B) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (B - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [39:0] f);
        for (int i = 4; i >= 0; i--) send_byte(f[i*8 +: 8]);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_regs(input string tag, input logic run, input logic [2:0] os,
                              input logic rng, input logic [15:0] div);
        check({tag, ".run"},   32'(adc_run),   32'(run));
        check({tag, ".os"},    32'(adc_os),    32'(os));
        check({tag, ".range"}, 32'(adc_range), 32'(rng));
        check({tag, ".div"},   32'(adc_div),   32'(div));
    endtask

    typedef struct {
        string       name;
        logic [39:0] frame;
        logic        run;
        logic [2:0]  os;
        logic        rng;
        logic [15:0] div;
        int          dcv;
        int          dfe;
    } vec_t;

    vec_t vecs[6];

    // Frame-level reference model.
    // It applies the command rules directly to a whole frame.
    logic       m_run, m_rng;
    logic [2:0] m_os;
    logic [15:0] m_div;

    function automatic bit model_frame(input int cmd, input int hi, input int lo, input int sum);
        if (sum != (cmd + hi + lo) % 256) return 1'b0;
        if (cmd == 1) begin m_run = lo[0]; return 1'b1; end
        if (cmd == 2 && lo <= 6) begin m_os = 3'(lo); return 1'b1; end
        if (cmd == 3) begin m_rng = lo[0]; return 1'b1; end
        if (cmd == 4 && (hi * 256 + lo) != 0) begin m_div = 16'(hi * 256 + lo); return 1'b1; end
        return 1'b0;
    endfunction

    int cv0, fe0;
    logic exp_run;

    initial begin
        vecs[0] = '{"range_ok", 40'hA5_03_00_01_04, 1'b0, 3'd0, 1'b1, 16'd50000, 1, 0};
        vecs[1] = '{"div_ok",   40'hA5_04_C3_50_17, 1'b0, 3'd0, 1'b1, 16'hC350,  1, 0};
        vecs[2] = '{"div_zero", 40'hA5_04_00_00_04, 1'b0, 3'd0, 1'b1, 16'hC350,  0, 1};
        vecs[3] = '{"os_bsum",  40'hA5_02_00_05_00, 1'b0, 3'd0, 1'b1, 16'hC350,  0, 1};
        vecs[4] = '{"os_7",     40'hA5_02_00_07_09, 1'b0, 3'd0, 1'b1, 16'hC350,  0, 1};
        vecs[5] = '{"os_6",     40'hA5_02_00_06_08, 1'b0, 3'd6, 1'b1, 16'hC350,  1, 0};

        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_regs("reset", 1'b0, 3'd0, 1'b0, 16'd50000);
        check("reset.cfg_valid", 32'(cfg_valid), 32'd0);
        check("reset.frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (2 * B) @(negedge clk);

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            cv0 = cv_cnt;
            fe0 = fe_cnt;
            send_frame(vecs[i].frame);
            check_regs(vecs[i].name, vecs[i].run, vecs[i].os, vecs[i].rng, vecs[i].div);
            check({vecs[i].name, ".cv"}, 32'(cv_cnt - cv0), 32'(vecs[i].dcv));
            check({vecs[i].name, ".fe"}, 32'(fe_cnt - fe0), 32'(vecs[i].dfe));
            // Expected latency: 9.5 bit-times to the stop sample, plus synchroniser and pipeline cycles.
            if (i == 0) begin
                checks++;
                if (last_cv_cyc - sum_start_cyc < HALF + 9 * B + 1 ||
                    last_cv_cyc - sum_start_cyc > HALF + 9 * B + 8) begin
                    errors++;
                    $display("FAIL cv_latency: got %0d cycles, expected %0d..%0d",
                             last_cv_cyc - sum_start_cyc, HALF + 9 * B + 1, HALF + 9 * B + 8);
                end
            end
        end

        // Resync after junk bytes.
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        send_frame(40'hA5_01_00_01_02);
        check("resync.run", 32'(adc_run), 32'd1);
        check("resync.cv",  32'(cv_cnt - cv0), 32'd1);
        check("resync.fe",  32'(fe_cnt - fe0), 32'd0);

        // Glitch inside a frame. A spurious byte here would corrupt the checksum.
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_byte(8'hA5); send_byte(8'h01);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * B) @(negedge clk);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        repeat (4) @(negedge clk);
        check("glitch.run", 32'(adc_run), 32'd0);
        check("glitch.cv",  32'(cv_cnt - cv0), 32'd1);
        check("glitch.fe",  32'(fe_cnt - fe0), 32'd0);

        // Framing error mid-frame, then a break held low.
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_byte(8'hA5); send_byte(8'h01);
        send_byte(8'h00, 1'b0);
        repeat (2 * B) @(negedge clk);
        uart_rx = 1'b1;
        repeat (B) @(negedge clk);
        check("ferr.fe", 32'(fe_cnt - fe0), 32'd1);
        check("ferr.cv", 32'(cv_cnt - cv0), 32'd0);
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(40'hA5_03_00_00_03);
        check("ferr.recover.range", 32'(adc_range), 32'd0);
        check("ferr.recover.cv",    32'(cv_cnt - cv0), 32'd1);
        check("ferr.recover.fe",    32'(fe_cnt - fe0), 32'd0);

        // Long idle inside a frame.
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_byte(8'hA5); send_byte(8'h01);
        repeat (20 * B) @(negedge clk);
`ifdef UART_CMD_TIMEOUT_EN
        check("timeout.fe", 32'(fe_cnt - fe0), 32'd1);
        exp_run = 1'b0;
`else
        check("timeout.fe", 32'(fe_cnt - fe0), 32'd0);
        exp_run = 1'b1;
`endif
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
        repeat (4) @(negedge clk);
        check("timeout.run", 32'(adc_run), 32'(exp_run));
        check("timeout.cv",  32'(cv_cnt - cv0), 32'(exp_run));

        // Reset mid-frame.
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h12); send_byte(8'h34);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_regs("midrst", 1'b0, 3'd0, 1'b0, 16'd50000);
        check("midrst.cfg_valid", 32'(cfg_valid), 32'd0);
        check("midrst.frame_err", 32'(frame_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (B) @(negedge clk);
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(40'hA5_03_00_01_04);
        check("midrst.next.range", 32'(adc_range), 32'd1);
        check("midrst.next.cv",    32'(cv_cnt - cv0), 32'd1);

        // Random frames checked against the reference model.
        m_run = 1'b0; m_os = 3'd0; m_rng = 1'b1; m_div = 16'd50000;
        for (int n = 0; n < 12; n++) begin
            int cmd, hi, lo, sum;
            bit ok;
            logic [7:0] junk;
            cmd = int'($urandom_range(0, 5));
            hi  = int'($urandom_range(0, 255));
            lo  = int'($urandom_range(0, 255));
            if (cmd == 2) lo = int'($urandom_range(0, 9));
            if (cmd == 4 && $urandom_range(0, 3) == 0) begin hi = 0; lo = 0; end
            sum = (cmd + hi + lo) % 256;
            if ($urandom_range(0, 3) == 0) sum = sum ^ int'($urandom_range(1, 255));
            if ($urandom_range(0, 2) == 0) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk);
            end
            cv0 = cv_cnt; fe0 = fe_cnt;
            ok = model_frame(cmd, hi, lo, sum);
            send_frame({8'hA5, 8'(cmd), 8'(hi), 8'(lo), 8'(sum)});
            check_regs($sformatf("rand%0d", n), m_run, m_os, m_rng, m_div);
            check($sformatf("rand%0d.cv", n), 32'(cv_cnt - cv0), 32'(ok));
            check($sformatf("rand%0d.fe", n), 32'(fe_cnt - fe0), 32'(!ok));
        end

        check("pulse_overlap", 32'(overlap), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Host-to-FPGA UART command receiver, the inbound counterpart of the sample-streaming UART transmitter. It deserialises 8N1 bytes on `uart_rx` and parses fixed 5-byte command frames. Valid frames update a small set of AD7606 control registers: run/stop, oversampling, input range and sample-rate divisor. These registers drive the ADC driver in place of its hard-wired settings.

## Interface
- `CLK_FRE`, 50: input clock in MHz
- `UART_RATE`, 115200: baud rate
- `DIV_RST`, 50000: reset value of `adc_div`, which is 1 kHz at 50 MHz
- `clk` in 1: system clock
- `rst` in 1: reset, asynchronous, active-high
- `uart_rx` in 1: serial input, idle high, asynchronous to `clk`
- `adc_run` out 1: ADC continuous-sampling enable
- `adc_os` out 3: AD7606 oversampling code, 0..6
- `adc_range` out 1: 0 = ±5 V, 1 = ±10 V
- `adc_div` out 16: `clk` cycles per conversion, never 0
- `cfg_valid` out 1: one-cycle pulse when a frame is accepted
- `frame_err` out 1: one-cycle pulse when a frame or byte is rejected

## Operation
- **Baud timing**
  - `BAUD_CNT = CLK_FRE*1_000_000/UART_RATE` (434 at default).
  - `HALF = BAUD_CNT/2`.
- **Input sync:** `uart_rx` passes through a 2-flop synchroniser. Both flops reset to 1.
- **Byte receiver FSM:** IDLE → START → DATA → STOP → (WAIT_IDLE) → IDLE.
  - IDLE: a synchronised falling edge moves to START and clears the baud counter.
  - START: samples at `HALF`. Low → DATA. High → IDLE as a glitch, no error.
  - DATA: 8 samples, one every `BAUD_CNT`, LSB first.
  - STOP: samples after one further `BAUD_CNT`.
    - High → pulse `byte_vld` with the byte, then IDLE.
    - Low → byte is dropped, `rx_err` pulses, then WAIT_IDLE.
  - WAIT_IDLE: holds until the line is high (break handling).
- **Frame format:** `0xA5`, CMD, D_HI, D_LO, SUM.
  - SUM = (CMD + D_HI + D_LO) mod 256.
- **Parser FSM:** P_HDR → P_CMD → P_HI → P_LO → P_SUM → P_HDR.
  - P_HDR: ignores every byte except `0xA5`. No error for ignored bytes.
  - `0xA5` in any later position is treated as data.
- **Commands** (checked only in P_SUM, after the checksum matches):
  - `0x01` RUN: `adc_run <= D_LO[0]`
  - `0x02` OS: `adc_os <= D_LO[2:0]`. Rejected if D_LO > 6.
  - `0x03` RANGE: `adc_range <= D_LO[0]`
  - `0x04` DIV: `adc_div <= {D_HI,D_LO}`. Rejected if the value is 0.
  - Any other CMD is rejected.
- **Outcome:**
  - Accept: exactly one register updates and `cfg_valid` pulses.
  - Reject (bad SUM, bad CMD, illegal value): no register changes and `frame_err` pulses.
  - In both cases the parser returns to P_HDR.
- **`rx_err` while the parser is outside P_HDR:** parser → P_HDR and `frame_err` pulses. In P_HDR, `rx_err` is silent.

## Timing
- **Reset values:** `adc_run`=0, `adc_os`=0, `adc_range`=0, `adc_div`=`DIV_RST`, `cfg_valid`=0, `frame_err`=0. Both FSMs are in IDLE / P_HDR.
- `byte_vld` asserts the cycle after the stop-bit sample, which is 9.5 bit-times after the start edge.
- Register update, `cfg_valid` and `frame_err` all occur 1 cycle after the SUM `byte_vld`.
- **Back-to-back bytes:** a new start edge is accepted the cycle after STOP completes. The next frame may begin immediately after SUM.
- `cfg_valid` and `frame_err` are never high in the same cycle.
- `rst` asserted mid-byte or mid-frame returns everything to reset values immediately. A partial frame is discarded.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - The parser has an idle counter, active while outside P_HDR.
  - It resets on every `byte_vld`.
  - On reaching 16·`BAUD_CNT` cycles the parser → P_HDR and `frame_err` pulses once.
- `UART_CMD_TIMEOUT_EN` undefined: no counter. The parser waits indefinitely for the next byte.

## Structure
- **Package `uart_cmd_pkg`:**
  - `HDR=8'hA5`
  - Command codes `CMD_RUN/CMD_OS/CMD_RANGE/CMD_DIV`
  - `OS_MAX=6`
  - Enums `rx_state_t` and `parse_state_t`
- **Sub-module `uart_rx_byte`:** synchroniser plus byte FSM, outputs `byte_vld`, `byte_data[7:0]`, `rx_err`.
- The parser, timeout and registers live in `uart_cmd_rx`.

## Test plan
- **Valid RANGE frame:** send A5 03 00 01 04 → `adc_range`=1, one `cfg_valid` pulse 1 cycle after the SUM byte. Other outputs keep their reset values.
- **DIV and illegal DIV:** send A5 04 C3 50 17 → `adc_div`=0xC350. Then send A5 04 00 00 04 → `frame_err` pulses and `adc_div` stays 0xC350.
- **Checksum and OS range:** send A5 02 00 05 00 (bad SUM) → `frame_err`, `adc_os`=0. Then send A5 02 00 07 09 → `frame_err`. Then send A5 02 00 06 08 → `adc_os`=6.
- **Resync:** send junk 00 FF 12, then A5 01 00 01 02 → `adc_run`=1 and no `frame_err`. A 0.3-bit low glitch on the idle line → no byte and no error.
- **Framing error mid-frame:** send A5 01, then a byte with stop bit low → `frame_err`. The receiver waits for line high, then a valid frame is accepted.
- **Timeout and reset:**
  - With the macro defined: A5 01, then idle 16 bit-times → one `frame_err` pulse.
  - `rst` pulsed mid-frame → all outputs at reset values, and the next full frame is accepted.
